// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: opcodes, control word, ID/EX payload and the
// combinational control/immediate decoders used by the decode stage.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned REG_AW = 5;
  localparam logic [XLEN-1:0] RST_PC = XLEN'(0);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  // IMM_NONE covers R-type and NOPs, which carry a zero immediate.
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_J    = 3'd4
  } imm_src_e;

  typedef struct packed {
    logic      reg_write;
    logic      result_src;
    logic      mem_write;
    logic      branch;
    logic      jump;
    logic      alu_src;
    alu_ctrl_e alu_control;
    imm_src_e  imm_src;
  } ctrl_t;

  typedef struct packed {
    logic              reg_write;
    logic              result_src;
    logic              mem_write;
    logic              branch;
    logic              jump;
    logic              alu_src;
    alu_ctrl_e         alu_control;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm_ext;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus4;
  } idex_t;

  function automatic idex_t idex_bubble();
    idex_t b;
    b          = '0;
    b.pc       = RST_PC;
    b.pc_plus4 = RST_PC;
    return b;
  endfunction

  // sub_ok is only set for R-type; addi with imm bit 10 set must still add.
  function automatic alu_ctrl_e alu_decode(input logic [2:0] funct3, input logic sub_ok,
                                           input logic funct7_b5);
    alu_ctrl_e a;
    unique case (funct3)
      3'b000:  a = (sub_ok && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b010:  a = ALU_SLT;
      3'b110:  a = ALU_OR;
      3'b111:  a = ALU_AND;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

  function automatic ctrl_t control_decode(input logic [6:0] opcode, input logic [2:0] funct3,
                                           input logic funct7_b5);
    ctrl_t c;
    c             = '0;
    c.alu_control = ALU_ADD;
    c.imm_src     = IMM_NONE;
    unique case (opcode)
      OP_LW: begin
        c.reg_write  = 1'b1;
        c.result_src = 1'b1;
        c.alu_src    = 1'b1;
        c.imm_src    = IMM_I;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
        c.imm_src   = IMM_S;
      end
      OP_R: begin
        c.reg_write   = 1'b1;
        c.alu_control = alu_decode(funct3, 1'b1, funct7_b5);
      end
      OP_IALU: begin
        c.reg_write   = 1'b1;
        c.alu_src     = 1'b1;
        c.alu_control = alu_decode(funct3, 1'b0, funct7_b5);
        c.imm_src     = IMM_I;
      end
      OP_BEQ: begin
        c.branch      = 1'b1;
        c.alu_control = ALU_SUB;
        c.imm_src     = IMM_B;
      end
      OP_JAL: begin
        c.reg_write = 1'b1;
        c.jump      = 1'b1;
        c.imm_src   = IMM_J;
      end
      default: c = c;
    endcase
    return c;
  endfunction

  function automatic logic [XLEN-1:0] imm_extend(input logic [31:7] instr_hi,
                                                 input imm_src_e src);
    logic [31:0]     i;
    logic [XLEN-1:0] imm;
    i = {instr_hi, 7'b0};
    unique case (src)
      IMM_I:   imm = {{20{i[31]}}, i[31:20]};
      IMM_S:   imm = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_J:   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm = XLEN'(0);
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/reg_file_2r1w.sv
// 32x32 register file: two async read ports, one sync write port, x0 reads zero,
// and same-cycle write data forwarded onto matching read ports.
module reg_file_2r1w
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] a1_i,
  input  logic [REG_AW-1:0] a2_i,
  input  logic              we_i,
  input  logic [REG_AW-1:0] a3_i,
  input  logic [XLEN-1:0]   wd_i,
  output logic [XLEN-1:0]   rd1_c,
  output logic [XLEN-1:0]   rd2_c
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wr_en;

  assign wr_en = we_i && (a3_i != REG_AW'(0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= XLEN'(0);
    end else if (wr_en) begin
      regs_q[a3_i] <= wd_i;
    end
  end

  // Write-through lets the consumer see this cycle's writeback without a bypass stage.
  always_comb begin
    rd1_c = regs_q[a1_i];
    rd2_c = regs_q[a2_i];
    if (wr_en && (a3_i == a1_i)) rd1_c = wd_i;
    if (wr_en && (a3_i == a2_i)) rd2_c = wd_i;
    if (a1_i == REG_AW'(0)) rd1_c = XLEN'(0);
    if (a2_i == REG_AW'(0)) rd2_c = XLEN'(0);
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes InstrD, reads the register file, extends the
// immediate and registers everything into the ID/EX pipeline register.
module decode_stage
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       InstrD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic              FlushE,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RDW,
  input  logic [XLEN-1:0]   ResultW,
  output logic              RegWriteE,
  output logic              ResultSrcE,
  output logic              MemWriteE,
  output logic              BranchE,
  output logic              JumpE,
  output logic              ALUSrcE,
  output logic [2:0]        ALUControlE,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [REG_AW-1:0] Rs1E,
  output logic [REG_AW-1:0] Rs2E,
  output logic [REG_AW-1:0] RdE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E
);

  logic [REG_AW-1:0] rs1, rs2, rd;
  logic [XLEN-1:0]   rd1_c, rd2_c;
  ctrl_t             ctrl;
  idex_t             idex_d, idex_q;

  assign rs1 = InstrD[19:15];
  assign rs2 = InstrD[24:20];
  assign rd  = InstrD[11:7];

  assign ctrl = control_decode(InstrD[6:0], InstrD[14:12], InstrD[30]);

  reg_file_2r1w u_rf (
    .clk   (clk),
    .rst_n (rst),
    .a1_i  (rs1),
    .a2_i  (rs2),
    .we_i  (RegWriteW),
    .a3_i  (RDW),
    .wd_i  (ResultW),
    .rd1_c (rd1_c),
    .rd2_c (rd2_c)
  );

  // Flush overrides capture; the regfile write above is unaffected by it.
  always_comb begin
    idex_d = idex_bubble();
    if (!FlushE) begin
      idex_d.reg_write   = ctrl.reg_write;
      idex_d.result_src  = ctrl.result_src;
      idex_d.mem_write   = ctrl.mem_write;
      idex_d.branch      = ctrl.branch;
      idex_d.jump        = ctrl.jump;
      idex_d.alu_src     = ctrl.alu_src;
      idex_d.alu_control = ctrl.alu_control;
      idex_d.rd1         = rd1_c;
      idex_d.rd2         = rd2_c;
      idex_d.imm_ext     = imm_extend(InstrD[31:7], ctrl.imm_src);
      idex_d.rs1         = rs1;
      idex_d.rs2         = rs2;
      idex_d.rd          = rd;
      idex_d.pc          = PCD;
      idex_d.pc_plus4    = PCPlus4D;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idex_q <= idex_bubble();
    else      idex_q <= idex_d;
  end

  assign RegWriteE   = idex_q.reg_write;
  assign ResultSrcE  = idex_q.result_src;
  assign MemWriteE   = idex_q.mem_write;
  assign BranchE     = idex_q.branch;
  assign JumpE       = idex_q.jump;
  assign ALUSrcE     = idex_q.alu_src;
  assign ALUControlE = idex_q.alu_control;
  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign ImmExtE     = idex_q.imm_ext;
  assign Rs1E        = idex_q.rs1;
  assign Rs2E        = idex_q.rs2;
  assign RdE         = idex_q.rd;
  assign PCE         = idex_q.pc;
  assign PCPlus4E    = idex_q.pc_plus4;

endmodule
